// File: rtl/mem_bank_sequencer.sv
// Bus-side sequencer that drives bank select, address, data and active-low strobes
// for one byte access per request, using a fixed setup/access/hold wait-state timeline.
module mem_bank_sequencer #(
    parameter int ADDR_W        = 13,
    parameter int SETUP_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_bank,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic [7:5]        ctrl_reg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_oe_,
    output logic              mem_we_
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int MAX_SA = (SETUP_CYCLES > ACCESS_CYCLES) ? SETUP_CYCLES : ACCESS_CYCLES;
    localparam int MAX_C  = (MAX_SA > HOLD_CYCLES) ? MAX_SA : HOLD_CYCLES;
    localparam int CNT_W  = (MAX_C <= 1) ? 1 : $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    // A zero-length hold phase is skipped entirely, so its load value is never used.
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              write_q,     write_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic [2:0]        bank_q,      bank_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [7:0]        wdata_q,     wdata_d;
    logic              oe_n_q,      oe_n_d;
    logic              we_n_q,      we_n_d;

    // Next-state and registered-output computation for the access timeline.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        bank_d      = bank_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    bank_d      = req_bank;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    write_d     = req_write;
                    cnt_d       = SETUP_LOAD;
                    req_ready_d = 1'b0;
                    state_d     = ST_SETUP;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = ACCESS_LOAD;
                    state_d = ST_ACCESS;
                    if (write_q) begin
                        we_n_d = 1'b0;
                    end else begin
                        oe_n_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    // Sample read data on the same edge that releases the strobe.
                    if (!write_q) begin
                        rsp_rdata_d = mem_rdata;
                    end else begin
                        rsp_rdata_d = rsp_rdata_q;
                    end
                    oe_n_d = 1'b1;
                    we_n_d = 1'b1;
                    if (HOLD_CYCLES == 0) begin
                        state_d     = ST_IDLE;
                        req_ready_d = 1'b1;
                        rsp_valid_d = 1'b1;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                oe_n_d      = 1'b1;
                we_n_d      = 1'b1;
            end
        endcase
    end

    // State and output registers; reset releases the strobes without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            write_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            bank_q      <= 3'b000;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= 8'h00;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ctrl_reg  = bank_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_oe_   = oe_n_q;
    assign mem_we_   = we_n_q;

endmodule

// File: tb/tb_mem_bank_sequencer.sv
// Directed bench for mem_bank_sequencer: default timing on one instance and a
// long-setup/short-access/no-hold configuration on a second instance.
module tb_mem_bank_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_b;
    logic [2:0]  req_bank;
    logic [12:0] req_addr;
    logic        req_write;
    logic [7:0]  req_wdata;

    logic        req_ready, rsp_valid, mem_oe_, mem_we_;
    logic [7:0]  rsp_rdata, mem_wdata, mem_rdata;
    logic [7:5]  ctrl_reg;
    logic [12:0] mem_addr;

    logic        req_ready_b, rsp_valid_b, mem_oe_b, mem_we_b;
    logic [7:0]  rsp_rdata_b, mem_wdata_b, mem_rdata_b;
    logic [7:5]  ctrl_reg_b;
    logic [12:0] mem_addr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model: data is only driven while output enable is low; bank b returns 0xA0+b.
    assign mem_rdata   = mem_oe_  ? 8'hFF : (8'hA0 | {5'b00000, ctrl_reg});
    assign mem_rdata_b = mem_oe_b ? 8'hFF : (8'hA0 | {5'b00000, ctrl_reg_b});

    mem_bank_sequencer #(.ADDR_W(13), .SETUP_CYCLES(1), .ACCESS_CYCLES(2), .HOLD_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bank(req_bank), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ctrl_reg(ctrl_reg), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_oe_(mem_oe_), .mem_we_(mem_we_)
    );

    mem_bank_sequencer #(.ADDR_W(13), .SETUP_CYCLES(3), .ACCESS_CYCLES(1), .HOLD_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_bank(req_bank), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .ctrl_reg(ctrl_reg_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .mem_oe_(mem_oe_b), .mem_we_(mem_we_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a read on the default instance and wait (bounded) for its response.
    task automatic do_read(input logic [2:0] b, input string tag);
        int lat;
        chk({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_bank  = b;
        req_addr  = {10'd0, b};
        req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        chk({tag, "_bank"}, ctrl_reg, b);
        chk({tag, "_addr"}, mem_addr, {19'd0, 10'd0, b});
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_rdata"}, rsp_rdata, 8'hA0 + {5'b00000, b});
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        req_bank    = 3'd0;
        req_addr    = 13'd0;
        req_write   = 1'b0;
        req_wdata   = 8'h00;
        repeat (3) tick();

        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_addr", mem_addr, 13'h0000);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_ready_b", req_ready_b, 1);
        reset = 1'b0;

        // Idle after reset release.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ready", req_ready, 1);
            chk("idle_ctrl", ctrl_reg, 3'b000);
            chk("idle_oe", mem_oe_, 1);
            chk("idle_we", mem_we_, 1);
            chk("idle_rsp", rsp_valid, 0);
        end

        // Read bank 5, addr 0x0123: cycle n is now.
        req_valid = 1'b1; req_bank = 3'd5; req_addr = 13'h0123; req_write = 1'b0;
        tick();                                            // n+1
        req_valid = 1'b0;
        chk("rd_n1_ctrl", ctrl_reg, 3'b101);
        chk("rd_n1_addr", mem_addr, 13'h0123);
        chk("rd_n1_oe", mem_oe_, 1);
        chk("rd_n1_ready", req_ready, 0);
        tick();                                            // n+2
        chk("rd_n2_oe", mem_oe_, 0);
        chk("rd_n2_we", mem_we_, 1);
        tick();                                            // n+3
        chk("rd_n3_oe", mem_oe_, 0);
        tick();                                            // n+4
        chk("rd_n4_oe", mem_oe_, 1);
        chk("rd_n4_ctrl", ctrl_reg, 3'b101);
        chk("rd_n4_rsp", rsp_valid, 0);
        tick();                                            // n+5
        chk("rd_n5_rsp", rsp_valid, 1);
        chk("rd_n5_rdata", rsp_rdata, 8'hA5);
        chk("rd_n5_ready", req_ready, 1);
        tick();                                            // n+6
        chk("rd_n6_rsp", rsp_valid, 0);

        // Write bank 7 data 0x3C, then a read of bank 0 in the response cycle.
        req_valid = 1'b1; req_bank = 3'd7; req_addr = 13'h0042; req_write = 1'b1; req_wdata = 8'h3C;
        tick();                                            // n+1
        req_valid = 1'b0; req_write = 1'b0; req_wdata = 8'h00;
        chk("wr_n1_wdata", mem_wdata, 8'h3C);
        chk("wr_n1_ctrl", ctrl_reg, 3'b111);
        chk("wr_n1_we", mem_we_, 1);
        tick();                                            // n+2
        chk("wr_n2_we", mem_we_, 0);
        chk("wr_n2_oe", mem_oe_, 1);
        chk("wr_n2_wdata", mem_wdata, 8'h3C);
        req_valid = 1'b1; req_bank = 3'd3;                 // must be ignored while busy
        tick();                                            // n+3
        req_valid = 1'b0;
        chk("wr_n3_we", mem_we_, 0);
        chk("wr_n3_ctrl", ctrl_reg, 3'b111);
        tick();                                            // n+4
        chk("wr_n4_we", mem_we_, 1);
        chk("wr_n4_ctrl", ctrl_reg, 3'b111);
        chk("wr_n4_wdata", mem_wdata, 8'h3C);
        tick();                                            // n+5
        chk("wr_n5_rsp", rsp_valid, 1);
        chk("wr_n5_rdata_hold", rsp_rdata, 8'hA5);
        chk("wr_n5_ready", req_ready, 1);
        req_valid = 1'b1; req_bank = 3'd0; req_addr = 13'h1FFF; req_write = 1'b0;
        tick();                                            // second request n+1
        req_valid = 1'b0;
        chk("b2b_ctrl", ctrl_reg, 3'b000);
        chk("b2b_addr", mem_addr, 13'h1FFF);
        chk("b2b_ready", req_ready, 0);
        chk("b2b_rsp", rsp_valid, 0);
        chk("b2b_we", mem_we_, 1);
        tick(); chk("b2b_n2_oe", mem_oe_, 0);
        tick(); chk("b2b_n3_oe", mem_oe_, 0);
        tick(); chk("b2b_n4_oe", mem_oe_, 1);
        tick();
        chk("b2b_n5_rsp", rsp_valid, 1);
        chk("b2b_n5_rdata", rsp_rdata, 8'hA0);

        // Back-to-back read sweep over all banks.
        for (int b = 0; b < 8; b++) begin
            do_read(3'(b), "sweep");
        end
        tick();

        // Second instance: setup 3, access 1, no hold.
        chk("cfg_ready", req_ready_b, 1);
        req_valid_b = 1'b1; req_bank = 3'd2; req_addr = 13'h0ABC; req_write = 1'b0; req_wdata = 8'h00;
        tick();                                            // n+1
        req_valid_b = 1'b0;
        chk("cfg_n1_ctrl", ctrl_reg_b, 3'b010);
        chk("cfg_n1_addr", mem_addr_b, 13'h0ABC);
        chk("cfg_n1_oe", mem_oe_b, 1);
        tick(); chk("cfg_n2_oe", mem_oe_b, 1);
        tick(); chk("cfg_n3_oe", mem_oe_b, 1);
        tick();                                            // n+4
        chk("cfg_n4_oe", mem_oe_b, 0);
        chk("cfg_n4_rsp", rsp_valid_b, 0);
        tick();                                            // n+5
        chk("cfg_n5_oe", mem_oe_b, 1);
        chk("cfg_n5_rsp", rsp_valid_b, 1);
        chk("cfg_n5_rdata", rsp_rdata_b, 8'hA2);
        chk("cfg_n5_we", mem_we_b, 1);
        chk("cfg_n5_wdata", mem_wdata_b, 8'h00);
        tick();
        chk("cfg_n6_rsp", rsp_valid_b, 0);

        // Asynchronous reset in the middle of a write access.
        req_valid = 1'b1; req_bank = 3'd4; req_addr = 13'h0777; req_write = 1'b1; req_wdata = 8'h5A;
        tick();                                            // n+1
        req_valid = 1'b0; req_write = 1'b0;
        tick();                                            // n+2, strobe low
        chk("arst_pre_we", mem_we_, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_we", mem_we_, 1);
        chk("arst_oe", mem_oe_, 1);
        chk("arst_ctrl", ctrl_reg, 3'b000);
        chk("arst_ready", req_ready, 1);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("arst_no_rsp", rsp_valid, 0);
            chk("arst_idle_we", mem_we_, 1);
        end
        do_read(3'd3, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
